wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset.
REQ-002 Parameter DEPTH SHALL default to 2 and set the multiply/divide result buffer entries (2..4).
REQ-003 Parameter STARVE_LIMIT SHALL default to 4 and set the consecutive lost-arbitration cycles before a forced drain (1..15).
REQ-004 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-low reset
- PipeRegWrite  in  1  writeback-stage write enable
- PipeDest  in  5  writeback-stage destination
- PipeResult  in  32  writeback-stage data
- MdValid  in  1  mul/div result offered
- MdDest  in  5  mul/div destination
- MdResult  in  32  mul/div data
- MdReady  out  1  buffer can accept
- QueryRs  in  5  decode-stage source register
- QueryRt  in  5  decode-stage source register
- PendingHazard  out  1  query hits a buffered destination
- StallPipe  out  1  freeze pipeline this cycle
- RfWrite  out  1  register-file write enable
- RfDest  out  5  register-file write address
- RfData  out  32  register-file write data

Function
REQ-005 A mul/div transfer SHALL occur on a rising clk edge with MdValid=1 and MdReady=1; MdReady SHALL equal "buffer not full" with no same-cycle pop credit.
REQ-006 A transfer with MdDest=0 SHALL be accepted and discarded, not enqueued.
REQ-007 The buffer SHALL be FIFO; an accepted entry SHALL be writable no earlier than the next cycle (no bypass).
REQ-008 The FSM SHALL have states NORMAL and FORCE.
REQ-009 In NORMAL, a pipeline write (PipeRegWrite=1, PipeDest!=0) SHALL win the port: RfWrite=1, RfDest=PipeDest, RfData=PipeResult, combinationally.
REQ-010 In NORMAL with no pipeline write and a non-empty buffer, the head SHALL be written and popped that cycle.
REQ-011 The wait counter SHALL increment each NORMAL cycle the head is valid but not written, and clear on any pop or when empty.
REQ-012 When the counter reaches STARVE_LIMIT, the next state SHALL be FORCE.
REQ-013 In FORCE: StallPipe=1, head written and popped regardless of PipeRegWrite, pipeline write suppressed; next state NORMAL, counter cleared.
REQ-014 StallPipe SHALL be 1 only in FORCE (Moore output).
REQ-015 When a pipeline write commits with PipeDest equal to a buffered entry's destination, that entry SHALL be marked dead; a dead head SHALL be popped without asserting RfWrite, and this SHALL count as a pop.
REQ-016 PendingHazard SHALL be 1 when a nonzero QueryRs or QueryRt equals the destination of any live buffered entry, combinationally.
REQ-017 Simultaneous enqueue and pop SHALL both take effect; occupancy unchanged.
REQ-018 RfWrite SHALL never be 1 with RfDest=0.

Reset
REQ-019 While reset=0: buffer empty, all entries invalid, counter 0, state NORMAL, RfWrite=0, StallPipe=0, PendingHazard=0, MdReady=0.
REQ-020 Reset asserted mid-operation SHALL discard buffered results; first write after release SHALL be a fresh source.

Structure
REQ-021 Package wb_arb_pkg SHALL hold the state type, the buffer entry record (valid, dead, dest, data), and default DEPTH/STARVE_LIMIT constants.
REQ-022 The buffer SHALL be sub-module wb_fifo (push/pop/full/empty, entry array exposed for hazard and kill comparison).

Verification
REQ-023 Pipe idle, MdValid with dest 5, data 0x1234 -> write r5=0x1234 exactly one cycle after acceptance.
REQ-024 Buffer holds r7, pipe writes every cycle, STARVE_LIMIT=4 -> StallPipe=1 on 5th cycle, r7 written, pipe write deferred; pipe resumes next cycle.
REQ-025 Fill 2 entries (r3,r4), pipe busy -> MdReady=0; third offer held until pop, then accepted.
REQ-026 Buffer holds r9=0xAAAA, pipe writes r9=0xBBBB -> entry killed; r9 remains 0xBBBB; no RfWrite for killed entry.
REQ-027 Buffer holds r12, QueryRt=12 -> PendingHazard=1; QueryRs=0, QueryRt=0 -> PendingHazard=0.
REQ-028 Reset pulsed with 2 entries queued -> MdReady=0 during reset, buffer empty after release, no stale write.

Source files
------------

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types and defaults for the register-file writeback
//            arbiter: FSM state encoding, buffered mul/div result record,
//            the tag view used for hazard/kill compares, default sizes.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int DEFAULT_DEPTH        = 2;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    // Arbiter FSM state
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_NORMAL = 1'b0;
    localparam arb_state_t ST_FORCE  = 1'b1;

    // One buffered mul/div result
    typedef struct packed {
        logic        valid;
        logic        dead;
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_entry_t;

    // Data-less view of an entry, enough for destination compares
    typedef struct packed {
        logic        valid;
        logic        dead;
        logic [4:0]  dest;
    } wb_tag_t;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Small FIFO of mul/div results waiting for a register-file port.
//            Entries can be marked dead in place when a younger pipeline
//            write to the same destination commits.
// Ports    : clk, reset (async active-low)
//            i_push/i_push_dest/i_push_data : enqueue (ignored when full)
//            i_pop                          : dequeue head (ignored when empty)
//            i_kill/i_kill_dest             : mark matching live entries dead
//            o_full/o_empty                 : occupancy flags
//            o_head                         : entry at the read pointer
//            o_tags                         : per-slot valid/dead/dest view
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic [4:0]  i_push_dest,
    input  logic [31:0] i_push_data,
    input  logic        i_pop,
    input  logic        i_kill,
    input  logic [4:0]  i_kill_dest,
    output logic        o_full,
    output logic        o_empty,
    output wb_entry_t   o_head,
    output wb_tag_t     o_tags [DEPTH]
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    wb_entry_t         entries_q [DEPTH];
    wb_entry_t         entries_d [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              w_push_ok;
    logic              w_pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (count_q == CNT_FULL);
    assign o_empty   = (count_q == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = entries_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_tags[i].valid = entries_q[i].valid;
            o_tags[i].dead  = entries_q[i].dead;
            o_tags[i].dest  = entries_q[i].dest;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Kill only applies to entries already buffered; a result pushed
        // in the same cycle lands after the compare.
        if (i_kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].valid && (entries_q[i].dest == i_kill_dest)) begin
                    entries_d[i].dead = 1'b1;
                end
            end
        end

        if (w_pop_ok) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            entries_d[rd_ptr_q].dead  = 1'b0;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // Push needs a free slot, so the write slot never aliases the head
        if (w_push_ok) begin
            entries_d[wr_ptr_q].valid = 1'b1;
            entries_d[wr_ptr_q].dead  = 1'b0;
            entries_d[wr_ptr_q].dest  = i_push_dest;
            entries_d[wr_ptr_q].data  = i_push_data;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Shares one register-file write port between the pipeline
//            writeback stage and a buffered mul/div result queue. The
//            pipeline normally wins; a queued result that loses too many
//            cycles in a row forces a one-cycle pipeline stall to drain.
// Ports    : clk, reset (async active-low)
//            PipeRegWrite/PipeDest/PipeResult : writeback-stage write
//            MdValid/MdDest/MdResult/MdReady  : mul/div result handshake
//            QueryRs/QueryRt/PendingHazard    : decode-stage hazard query
//            StallPipe                        : pipeline freeze (FORCE state)
//            RfWrite/RfDest/RfData            : register-file write port
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PipeRegWrite,
    input  logic [4:0]  PipeDest,
    input  logic [31:0] PipeResult,
    input  logic        MdValid,
    input  logic [4:0]  MdDest,
    input  logic [31:0] MdResult,
    output logic        MdReady,
    input  logic [4:0]  QueryRs,
    input  logic [4:0]  QueryRt,
    output logic        PendingHazard,
    output logic        StallPipe,
    output logic        RfWrite,
    output logic [4:0]  RfDest,
    output logic [31:0] RfData
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic        w_full;
    logic        w_empty;
    wb_entry_t   w_head;
    wb_tag_t     w_tags [DEPTH];
    logic        w_pipe_wr;
    logic        w_head_live;
    logic        w_push;
    logic        w_pop;
    logic        w_kill;
    logic        w_rf_we;
    logic [4:0]  w_rf_dest;
    logic [31:0] w_rf_data;
    logic        w_hazard;

    assign w_pipe_wr   = PipeRegWrite && (PipeDest != 5'd0);
    assign w_head_live = w_head.valid && !w_head.dead;

    // No pop credit: readiness depends only on the registered occupancy
    assign MdReady = reset && !w_full;
    // Zero-destination results are handshaken but never stored
    assign w_push  = MdValid && MdReady && (MdDest != 5'd0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_dest (MdDest),
        .i_push_data (MdResult),
        .i_pop       (w_pop),
        .i_kill      (w_kill),
        .i_kill_dest (PipeDest),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head),
        .o_tags      (w_tags)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        w_pop      = 1'b0;
        w_kill     = 1'b0;
        w_rf_we    = 1'b0;
        w_rf_dest  = 5'd0;
        w_rf_data  = 32'd0;

        case (state_q)
            ST_FORCE: begin
                // Pipeline write is dropped; the stalled instruction retries
                if (!w_empty) begin
                    w_pop = 1'b1;
                end
                if (w_head_live) begin
                    w_rf_we   = 1'b1;
                    w_rf_dest = w_head.dest;
                    w_rf_data = w_head.data;
                end
                wait_cnt_d = 4'd0;
                state_d    = ST_NORMAL;
            end
            default: begin
                if (w_pipe_wr) begin
                    w_rf_we   = 1'b1;
                    w_rf_dest = PipeDest;
                    w_rf_data = PipeResult;
                    w_kill    = 1'b1;
                end else if (w_head_live) begin
                    w_rf_we   = 1'b1;
                    w_rf_dest = w_head.dest;
                    w_rf_data = w_head.data;
                    w_pop     = 1'b1;
                end
                // A dead head needs no port, so it drains even under a pipe write
                if (w_head.valid && w_head.dead) begin
                    w_pop = 1'b1;
                end

                if (w_empty || w_pop) begin
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                    if (wait_cnt_d == LIMIT) begin
                        state_d = ST_FORCE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_tags[i].valid && !w_tags[i].dead) begin
                if (((QueryRs != 5'd0) && (w_tags[i].dest == QueryRs)) ||
                    ((QueryRt != 5'd0) && (w_tags[i].dest == QueryRt))) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    // The pipeline path is combinational, so gate it during reset
    assign RfWrite       = reset && w_rf_we;
    assign RfDest        = w_rf_dest;
    assign RfData        = w_rf_data;
    assign StallPipe     = (state_q == ST_FORCE);
    assign PendingHazard = w_hazard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_NORMAL;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter (default DEPTH=2,
//            STARVE_LIMIT=4). Inputs change 1 ns after a rising edge and
//            outputs are checked 2 ns later, mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        PipeRegWrite;
    logic [4:0]  PipeDest;
    logic [31:0] PipeResult;
    logic        MdValid;
    logic [4:0]  MdDest;
    logic [31:0] MdResult;
    logic        MdReady;
    logic [4:0]  QueryRs;
    logic [4:0]  QueryRt;
    logic        PendingHazard;
    logic        StallPipe;
    logic        RfWrite;
    logic [4:0]  RfDest;
    logic [31:0] RfData;

    int n_vec;
    int n_err;

    wb_arbiter u_dut (
        .clk           (clk),
        .reset         (reset),
        .PipeRegWrite  (PipeRegWrite),
        .PipeDest      (PipeDest),
        .PipeResult    (PipeResult),
        .MdValid       (MdValid),
        .MdDest        (MdDest),
        .MdResult      (MdResult),
        .MdReady       (MdReady),
        .QueryRs       (QueryRs),
        .QueryRt       (QueryRt),
        .PendingHazard (PendingHazard),
        .StallPipe     (StallPipe),
        .RfWrite       (RfWrite),
        .RfDest        (RfDest),
        .RfData        (RfData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check the write port; dest/data only matter when a write is expected
    task automatic chk_rf(input string tag, input logic we, input logic [4:0] dest,
                          input logic [31:0] data);
        chk({tag, ".we"}, {31'd0, RfWrite}, {31'd0, we});
        if (we) begin
            chk({tag, ".dest"}, {27'd0, RfDest}, {27'd0, dest});
            chk({tag, ".data"}, RfData, data);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk(tag, {31'd0, StallPipe}, {31'd0, exp});
    endtask

    task automatic chk_rdy(input string tag, input logic exp);
        chk(tag, {31'd0, MdReady}, {31'd0, exp});
    endtask

    task automatic chk_hz(input string tag, input logic exp);
        chk(tag, {31'd0, PendingHazard}, {31'd0, exp});
    endtask

    // Apply one cycle of inputs and let combinational outputs settle
    task automatic drive(input logic pw, input logic [4:0] pd, input logic [31:0] pr,
                         input logic mv, input logic [4:0] md, input logic [31:0] mr);
        PipeRegWrite = pw;
        PipeDest     = pd;
        PipeResult   = pr;
        MdValid      = mv;
        MdDest       = md;
        MdResult     = mr;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        QueryRs = 5'd0;
        QueryRt = 5'd0;

        // ---- reset state (MdValid offered to show MdReady held low) ----
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        chk_rdy("rst.mdready", 1'b0);
        chk_rf("rst.rf", 1'b0, 5'd0, 32'd0);
        chk_stall("rst.stall", 1'b0);
        QueryRs = 5'd4;
        #1;
        chk_hz("rst.hazard", 1'b0);
        QueryRs = 5'd0;
        tick();
        tick();
        reset = 1'b1;

        // ---- single result, idle pipe: written one cycle after accept ----
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        chk_rdy("md1.ready", 1'b1);
        chk_rf("md1.accept", 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_rf("md1.write", 1'b1, 5'd5, 32'h1234);
        tick();
        chk_rf("md1.after", 1'b0, 5'd0, 32'd0);

        // ---- zero destination: handshaken but discarded; pipe r0 ignored ----
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        chk_rdy("z.ready", 1'b1);
        tick();
        drive(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'd0);
        chk_rf("z.none", 1'b0, 5'd0, 32'd0);
        tick();

        // ---- starvation: r7 held while pipe writes r2 every cycle ----
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h77);
        chk_rf("st.pipe0", 1'b1, 5'd1, 32'h11);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 5'd2, 32'h20 + 32'(c), 1'b0, 5'd0, 32'd0);
            chk_stall($sformatf("st.nostall%0d", c), 1'b0);
            chk_rf($sformatf("st.pipe%0d", c), 1'b1, 5'd2, 32'h20 + 32'(c));
            tick();
        end
        drive(1'b1, 5'd2, 32'h25, 1'b0, 5'd0, 32'd0);
        chk_stall("st.force", 1'b1);
        chk_rf("st.drain", 1'b1, 5'd7, 32'h77);
        tick();
        drive(1'b1, 5'd2, 32'h25, 1'b0, 5'd0, 32'd0);
        chk_stall("st.resume", 1'b0);
        chk_rf("st.resume", 1'b1, 5'd2, 32'h25);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_rf("st.idle", 1'b0, 5'd0, 32'd0);
        tick();

        // ---- full buffer: r3, r4 queued, r5 held until a pop ----
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h33);
        chk_rdy("full.r3", 1'b1);
        tick();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44);
        chk_rdy("full.r4", 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55);
            chk_rdy($sformatf("full.held%0d", c), 1'b0);
            tick();
        end
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55);
        chk_stall("full.force", 1'b1);
        chk_rdy("full.nocredit", 1'b0);
        chk_rf("full.r3", 1'b1, 5'd3, 32'h33);
        tick();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55);
        chk_rdy("full.reopen", 1'b1);
        chk_rf("full.pipe", 1'b1, 5'd1, 32'h1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_rf("full.r4", 1'b1, 5'd4, 32'h44);
        tick();
        chk_rf("full.r5", 1'b1, 5'd5, 32'h55);
        tick();
        chk_rf("full.empty", 1'b0, 5'd0, 32'd0);

        // ---- kill: buffered r9 overwritten by pipeline r9 ----
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hAAAA);
        tick();
        QueryRs = 5'd9;
        drive(1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        chk_hz("kill.live", 1'b1);
        chk_rf("kill.pipe", 1'b1, 5'd9, 32'hBBBB);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_hz("kill.dead", 1'b0);
        chk_rf("kill.nowrite", 1'b0, 5'd0, 32'd0);
        tick();
        QueryRs = 5'd0;
        chk_rf("kill.gone", 1'b0, 5'd0, 32'd0);
        chk_rdy("kill.ready", 1'b1);
        tick();

        // ---- hazard query against buffered r12 ----
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC);
        tick();
        QueryRt = 5'd12;
        drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0);
        chk_hz("hz.rt", 1'b1);
        QueryRt = 5'd0;
        #1;
        chk_hz("hz.zero", 1'b0);
        QueryRs = 5'd12;
        #1;
        chk_hz("hz.rs", 1'b1);
        QueryRs = 5'd13;
        #1;
        chk_hz("hz.other", 1'b0);
        QueryRs = 5'd0;
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_rf("hz.drain", 1'b1, 5'd12, 32'hC);
        tick();

        // ---- reset mid-operation with two entries queued ----
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h2020);
        tick();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'h2121);
        tick();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd22, 32'h2222);
        reset = 1'b0;
        QueryRs = 5'd20;
        #1;
        chk_rdy("rr.mdready", 1'b0);
        chk_rf("rr.rf", 1'b0, 5'd0, 32'd0);
        chk_hz("rr.hazard", 1'b0);
        tick();
        tick();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_rdy("rr.ready", 1'b1);
        chk_hz("rr.empty", 1'b0);
        chk_rf("rr.nostale0", 1'b0, 5'd0, 32'd0);
        tick();
        chk_rf("rr.nostale1", 1'b0, 5'd0, 32'd0);
        QueryRs = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_rf("rr.fresh", 1'b1, 5'd6, 32'h6666);
        tick();
        chk_rf("rr.end", 1'b0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire
